mem_port_arbiter: RTL

//   Shares one single-ported unified instruction/data memory between the fetch stage (I port)
//   and the memory stage (D port). Sequences one transaction at a time over a req/gnt +

---
 rtl/mem_port_arbiter.sv | 93 +++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch (I) and data (D) ports.
// D has priority; a starvation counter forces an I win after STARVE_MAX consecutive D wins.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            srst_n,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [DW-1:0]   i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata,
    output logic            busy,
    output logic            err_unexp_rsp
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
    state_t          state_q;
    logic            own_d_q;
    logic [SW-1:0]   starve_q;
    logic            mem_req_q;
    logic            mem_we_q;
    logic [AW-1:0]   mem_addr_q;
    logic [DW-1:0]   mem_wdata_q;
    logic [DW/8-1:0] mem_be_q;
    logic            starved;
    logic            win_i;
    assign starved = starve_q == SW'(STARVE_MAX);
    assign win_i   = i_req & (~d_req | starved);
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            state_q     <= IDLE;
            own_d_q     <= 1'b0;
            starve_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (i_req | d_req) begin
                    state_q     <= REQ;
                    own_d_q     <= ~win_i;
                    mem_req_q   <= 1'b1;
                    mem_we_q    <= win_i ? 1'b0 : d_we;
                    mem_addr_q  <= win_i ? i_addr : d_addr;
                    mem_wdata_q <= win_i ? '0 : d_wdata;
                    mem_be_q    <= win_i ? '1 : d_be;
                    // count only D wins that made a pending fetch wait
                    starve_q    <= win_i ? '0 : (i_req && !starved) ? starve_q + 1'b1 : starve_q;
                end
                REQ: if (mem_gnt) begin
                    state_q   <= RSP;
                    mem_req_q <= 1'b0;
                end
                RSP: if (mem_rvalid) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_be        = mem_be_q;
    assign i_gnt         = (state_q == REQ) && mem_gnt && !own_d_q;
    assign d_gnt         = (state_q == REQ) && mem_gnt && own_d_q;
    assign i_rvalid      = (state_q == RSP) && mem_rvalid && !own_d_q;
    assign d_rvalid      = (state_q == RSP) && mem_rvalid && own_d_q;
    assign i_rdata       = mem_rdata;
    assign d_rdata       = mem_rdata;
    assign busy          = state_q != IDLE;
    assign err_unexp_rsp = mem_rvalid && (state_q != RSP);
endmodule
